// File: rtl/lte_dl_srcxn_inf.sv
// Downlink IQ source selector: TDM frame-bus slicer, pass-through, constant and test
// patterns, gated by a programmable cycle window inside the radio frame.
module lte_dl_srcxn_inf #(
  parameter int DW      = 32,
  parameter int NCH     = 8,
  parameter int SEL_W   = 4,
  parameter int SLOTS   = 8,
  parameter int CYC_LEN = 4915200,
  parameter int CNT_W   = 24,
  parameter int FH_DLY  = 7
) (
  input  logic                   clk,
  input  logic                   asy_rst,
  input  logic                   i_frame_hd,
  input  logic [NCH*DW-1:0]      i_data_bus,
  input  logic                   i_framn_hd,
  input  logic [DW-1:0]          i_datan_iq,
  input  logic                   i_test_en,
  input  logic [2:0]             i_mode,
  input  logic [SLOTS*SEL_W-1:0] i_sel_cfg,
  input  logic [DW-1:0]          i_const_iq,
  input  logic                   i_win_en,
  input  logic [CNT_W-1:0]       i_win_start,
  input  logic [CNT_W-1:0]       i_win_end,
  output logic [DW-1:0]          o_data_iq,
  output logic                   o_fram_hd,
  output logic                   o_slot_first
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int HW     = DW / 2;
  localparam int FH_LEN = FH_DLY + 2;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(CYC_LEN - 1);

  typedef enum logic [2:0] {
    M_PASS  = 3'd0,
    M_TDM   = 3'd1,
    M_CONST = 3'd2,
    M_RAMP  = 3'd3,
    M_CYC   = 3'd4
  } mode_e;

  // Test disable and the unused codes 5..7 all collapse onto pass-through.
  function automatic mode_e eff_mode(input logic en, input logic [2:0] m);
    mode_e r;
    r = M_PASS;
    if (en && (m <= 3'd4)) r = mode_e'(m);
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] slot_sel(input logic [SLOTS*SEL_W-1:0] cfg,
                                                input logic [SLOT_W-1:0] s);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (s == SLOT_W'(k)) r = cfg[k*SEL_W +: SEL_W];
    end
    return r;
  endfunction

  // Select codes that name no channel yield a zero sample.
  function automatic logic [DW-1:0] pick_ch(input logic [NCH*DW-1:0] snap,
                                            input logic [SEL_W-1:0] sel);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SEL_W'(k)) r = snap[k*DW +: DW];
    end
    return r;
  endfunction

  // S1 input registers
  logic [NCH*DW-1:0]      bus_p0_q;
  logic [DW-1:0]          datan_p0_q;
  logic [DW-1:0]          const_p0_q;
  logic [2:0]             mode_p0_q;
  logic                   test_en_p0_q;
  logic [SLOTS*SEL_W-1:0] sel_p0_q;
  logic                   win_en_p0_q;
  logic [CNT_W-1:0]       win_start_p0_q;
  logic [CNT_W-1:0]       win_end_p0_q;
  logic [SLOT_W-1:0]      slot_p0_q;

  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic [HW-1:0]          ramp_q, ramp_d;
  logic                   win_q, win_d;
  logic [NCH*DW-1:0]      snap_q;
  logic [1:0]             fn_q;
  logic [FH_LEN-1:0]      fh_q;

  // S2 mode mux / S3 gated output
  logic [DW-1:0]          data_p1_d, data_p1_q;
  logic                   sf_p1_q;
  logic [DW-1:0]          data_p2_q;
  logic                   fram_p2_d, fram_p2_q;
  logic                   sf_p2_q;
  mode_e                  mode_eff;

  always_comb begin
    mode_eff = eff_mode(test_en_p0_q, mode_p0_q);

    slot_d = slot_q + SLOT_W'(1);
    if (i_frame_hd || (slot_q == SLOT_LAST)) slot_d = '0;

    cyc_d = cyc_q + CNT_W'(1);
    if (i_framn_hd || (cyc_q == CYC_LAST)) cyc_d = '0;

    ramp_d = ramp_q + HW'(1);
    if (i_framn_hd) ramp_d = '0;

    // Start is tested first so start==end latches the window open.
    win_d = win_q;
    if (cyc_q == win_start_p0_q)    win_d = 1'b1;
    else if (cyc_q == win_end_p0_q) win_d = 1'b0;

    case (mode_eff)
      M_TDM:   data_p1_d = pick_ch(snap_q, slot_sel(sel_p0_q, slot_p0_q));
      M_CONST: data_p1_d = const_p0_q;
      M_RAMP:  data_p1_d = DW'({ramp_q, ramp_q});
      M_CYC:   data_p1_d = DW'(cyc_q);
      default: data_p1_d = datan_p0_q;
    endcase

    fram_p2_d = (mode_eff == M_TDM) ? fh_q[FH_LEN-1] : fn_q[1];
  end

  always_ff @(posedge clk) begin
    if (asy_rst) begin
      bus_p0_q     <= '0;
      datan_p0_q   <= '0;
      const_p0_q   <= '0;
      mode_p0_q    <= '0;
      test_en_p0_q <= 1'b0;
      slot_p0_q    <= '0;
      slot_q       <= '0;
      cyc_q        <= '0;
      ramp_q       <= '0;
      win_q        <= 1'b0;
      snap_q       <= '0;
      fn_q         <= '0;
      fh_q         <= '0;
      data_p1_q    <= '0;
      sf_p1_q      <= 1'b0;
      data_p2_q    <= '0;
      fram_p2_q    <= 1'b0;
      sf_p2_q      <= 1'b0;
    end else begin
      bus_p0_q     <= i_data_bus;
      datan_p0_q   <= i_datan_iq;
      const_p0_q   <= i_const_iq;
      mode_p0_q    <= i_mode;
      test_en_p0_q <= i_test_en;
      slot_p0_q    <= slot_q;
      slot_q       <= slot_d;
      cyc_q        <= cyc_d;
      ramp_q       <= ramp_d;
      win_q        <= win_d;
      if (slot_q == '0) snap_q <= bus_p0_q;
      fn_q         <= {fn_q[0], i_framn_hd};
      fh_q         <= {fh_q[FH_LEN-2:0], i_frame_hd};
      data_p1_q    <= data_p1_d;
      sf_p1_q      <= (slot_p0_q == '0);
      data_p2_q    <= (win_q || !win_en_p0_q) ? data_p1_q : '0;
      fram_p2_q    <= fram_p2_d;
      sf_p2_q      <= sf_p1_q;
    end
  end

  // Quasi-static configuration keeps sampling through reset so the window
  // compare sees real values on the first cycle after release.
  always_ff @(posedge clk) begin
    sel_p0_q       <= i_sel_cfg;
    win_en_p0_q    <= i_win_en;
    win_start_p0_q <= i_win_start;
    win_end_p0_q   <= i_win_end;
  end

  assign o_data_iq    = data_p2_q;
  assign o_fram_hd    = fram_p2_q;
  assign o_slot_first = sf_p2_q;

endmodule

// File: tb/tb_lte_dl_srcxn_inf.sv
// Directed bench for lte_dl_srcxn_inf, one task per scenario, CYC_LEN shortened to 64.
module tb_lte_dl_srcxn_inf;
  localparam int DW      = 32;
  localparam int NCH     = 8;
  localparam int SEL_W   = 4;
  localparam int SLOTS   = 8;
  localparam int CYC_LEN = 64;
  localparam int CNT_W   = 24;
  localparam int FH_DLY  = 7;

  logic                   clk = 1'b0;
  logic                   asy_rst;
  logic                   i_frame_hd;
  logic [NCH*DW-1:0]      i_data_bus;
  logic                   i_framn_hd;
  logic [DW-1:0]          i_datan_iq;
  logic                   i_test_en;
  logic [2:0]             i_mode;
  logic [SLOTS*SEL_W-1:0] i_sel_cfg;
  logic [DW-1:0]          i_const_iq;
  logic                   i_win_en;
  logic [CNT_W-1:0]       i_win_start;
  logic [CNT_W-1:0]       i_win_end;
  logic [DW-1:0]          o_data_iq;
  logic                   o_fram_hd;
  logic                   o_slot_first;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lte_dl_srcxn_inf #(
    .DW(DW), .NCH(NCH), .SEL_W(SEL_W), .SLOTS(SLOTS),
    .CYC_LEN(CYC_LEN), .CNT_W(CNT_W), .FH_DLY(FH_DLY)
  ) dut (
    .clk(clk), .asy_rst(asy_rst), .i_frame_hd(i_frame_hd), .i_data_bus(i_data_bus),
    .i_framn_hd(i_framn_hd), .i_datan_iq(i_datan_iq), .i_test_en(i_test_en),
    .i_mode(i_mode), .i_sel_cfg(i_sel_cfg), .i_const_iq(i_const_iq),
    .i_win_en(i_win_en), .i_win_start(i_win_start), .i_win_end(i_win_end),
    .o_data_iq(o_data_iq), .o_fram_hd(o_fram_hd), .o_slot_first(o_slot_first)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] chv(input int k);
    return DW'(32'h1000_0000 + k);
  endfunction

  task automatic set_default_sel();
    for (int s = 0; s < SLOTS; s++) i_sel_cfg[s*SEL_W +: SEL_W] = SEL_W'(7 - s);
  endtask

  task automatic test_reset();
    asy_rst = 1'b1;
    repeat (3) step();
    checks++; if (o_data_iq !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", o_data_iq); end
    checks++; if (o_fram_hd !== 1'b0) begin errors++; $display("FAIL rst_fram got %b exp 0", o_fram_hd); end
    checks++; if (o_slot_first !== 1'b0) begin errors++; $display("FAIL rst_slot got %b exp 0", o_slot_first); end
    asy_rst = 1'b0;
    step();
  endtask

  task automatic test_pass();
    i_mode = 3'd0; i_test_en = 1'b1; i_win_en = 1'b0;
    for (int j = 0; j < 24; j++) begin
      i_datan_iq = DW'(32'h100 + j);
      i_framn_hd = (j == 5);
      step();
      if (j >= 2) begin
        checks++;
        if (o_data_iq !== DW'(32'h100 + j - 2)) begin
          errors++; $display("FAIL pass_data j=%0d got %h exp %h", j, o_data_iq, DW'(32'h100 + j - 2));
        end
        checks++;
        if (o_fram_hd !== (j == 7)) begin
          errors++; $display("FAIL pass_fram j=%0d got %b exp %b", j, o_fram_hd, (j == 7));
        end
      end
    end
    i_framn_hd = 1'b0;
  endtask

  task automatic test_tdm();
    int s;
    set_default_sel();
    i_mode = 3'd1;
    for (int j = 0; j < 20; j++) begin
      i_frame_hd = (j == 0);
      step();
      if (j >= 3) begin
        s = (j - 3) % 8;
        checks++;
        if (o_data_iq !== chv(7 - s)) begin
          errors++; $display("FAIL tdm_data j=%0d got %h exp %h", j, o_data_iq, chv(7 - s));
        end
        checks++;
        if (o_slot_first !== (s == 0)) begin
          errors++; $display("FAIL tdm_slot_first j=%0d got %b exp %b", j, o_slot_first, (s == 0));
        end
        checks++;
        if (o_fram_hd !== (j == 9)) begin
          errors++; $display("FAIL tdm_fram j=%0d got %b exp %b", j, o_fram_hd, (j == 9));
        end
      end
    end
    i_frame_hd = 1'b0;
  endtask

  task automatic test_tdm_badsel();
    int s;
    logic [DW-1:0] exp;
    i_sel_cfg[2*SEL_W +: SEL_W] = 4'hF;
    step();
    for (int j = 0; j < 20; j++) begin
      i_frame_hd = (j == 0);
      step();
      if (j >= 3) begin
        s = (j - 3) % 8;
        exp = (s == 2) ? '0 : chv(7 - s);
        checks++;
        if (o_data_iq !== exp) begin
          errors++; $display("FAIL badsel_data j=%0d got %h exp %h", j, o_data_iq, exp);
        end
      end
    end
    i_frame_hd = 1'b0;
    set_default_sel();
  endtask

  task automatic test_window();
    int c;
    logic [DW-1:0] exp;
    i_mode = 3'd4; i_win_en = 1'b1; i_win_start = 24'd10; i_win_end = 24'd20;
    i_framn_hd = 1'b1;
    step();
    i_framn_hd = 1'b0;
    repeat (25) step();
    for (int j = 0; j < 100; j++) begin
      i_framn_hd = (j == 0);
      step();
      if (j >= 2) begin
        c = (j - 2) % 64;
        exp = (c >= 10 && c < 20) ? DW'(c) : '0;
        checks++;
        if (o_data_iq !== exp) begin
          errors++; $display("FAIL win_data j=%0d got %h exp %h", j, o_data_iq, exp);
        end
        checks++;
        if (o_fram_hd !== (j == 2)) begin
          errors++; $display("FAIL win_fram j=%0d got %b exp %b", j, o_fram_hd, (j == 2));
        end
      end
    end
    i_win_end = 24'd10;
    for (int j = 0; j < 150; j++) begin
      i_framn_hd = (j == 0);
      step();
      if (j >= 2) begin
        c = (j - 2) % 64;
        exp = (j - 2 >= 10) ? DW'(c) : '0;
        checks++;
        if (o_data_iq !== exp) begin
          errors++; $display("FAIL win_eq_data j=%0d got %h exp %h", j, o_data_iq, exp);
        end
      end
    end
    i_framn_hd = 1'b0; i_win_en = 1'b0; i_win_start = '0; i_win_end = '0;
  endtask

  task automatic test_ramp();
    logic [15:0] r;
    i_mode = 3'd3; i_win_en = 1'b0;
    for (int j = 0; j < 65542; j++) begin
      i_framn_hd = (j == 0);
      step();
      if (j == 2 || j == 3 || j == 65536 || j == 65537 || j == 65538 || j == 65539) begin
        r = 16'(j - 2);
        checks++;
        if (o_data_iq !== {r, r}) begin
          errors++; $display("FAIL ramp_data j=%0d got %h exp %h", j, o_data_iq, {r, r});
        end
      end
    end
    i_framn_hd = 1'b1;
    step();
    i_framn_hd = 1'b0;
    step();
    step();
    checks++;
    if (o_data_iq !== 32'h0000_0000) begin
      errors++; $display("FAIL ramp_restart0 got %h exp 00000000", o_data_iq);
    end
    step();
    checks++;
    if (o_data_iq !== 32'h0001_0001) begin
      errors++; $display("FAIL ramp_restart1 got %h exp 00010001", o_data_iq);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    i_mode = 3'd1; set_default_sel();
    i_frame_hd = 1'b1;
    step();
    i_frame_hd = 1'b0;
    repeat (4) step();
    asy_rst = 1'b1;
    step();
    checks++; if (o_data_iq !== '0) begin errors++; $display("FAIL midrst_data got %h exp 0", o_data_iq); end
    checks++; if (o_slot_first !== 1'b0) begin errors++; $display("FAIL midrst_slot got %b exp 0", o_slot_first); end
    checks++; if (o_fram_hd !== 1'b0) begin errors++; $display("FAIL midrst_fram got %b exp 0", o_fram_hd); end
    step();
    asy_rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      checks++;
      if (o_fram_hd !== 1'b0) begin
        errors++; $display("FAIL postrst_fram j=%0d got %b exp 0", j, o_fram_hd);
      end
      if (j == 1 || j == 2) begin
        checks++;
        if (o_data_iq !== '0) begin
          errors++; $display("FAIL postrst_zero j=%0d got %h exp 0", j, o_data_iq);
        end
      end
      if (j >= 2) begin
        s = (j - 2) % 8;
        checks++;
        if (o_slot_first !== (s == 0)) begin
          errors++; $display("FAIL postrst_slot j=%0d got %b exp %b", j, o_slot_first, (s == 0));
        end
      end
      if (j >= 10) begin
        s = (j - 2) % 8;
        checks++;
        if (o_data_iq !== chv(7 - s)) begin
          errors++; $display("FAIL postrst_data j=%0d got %h exp %h", j, o_data_iq, chv(7 - s));
        end
      end
    end
    for (int k = 0; k < 12; k++) begin
      i_frame_hd = (k == 0);
      step();
      if (k >= 3) begin
        s = (k - 3) % 8;
        checks++;
        if (o_data_iq !== chv(7 - s)) begin
          errors++; $display("FAIL realign_data k=%0d got %h exp %h", k, o_data_iq, chv(7 - s));
        end
        checks++;
        if (o_slot_first !== (s == 0)) begin
          errors++; $display("FAIL realign_slot k=%0d got %b exp %b", k, o_slot_first, (s == 0));
        end
      end
    end
    i_frame_hd = 1'b0;
  endtask

  task automatic test_mode_sel();
    logic [DW-1:0] exp;
    i_const_iq = 32'hDEAD_BEEF;
    for (int j = 0; j < 24; j++) begin
      i_datan_iq = DW'(32'hA000_0000 + j);
      i_frame_hd = (j == 0);
      if (j < 8) begin
        i_test_en = 1'b0; i_mode = 3'd2;
      end else if (j < 12) begin
        i_test_en = 1'b1; i_mode = 3'd5;
      end else if (j < 16) begin
        i_test_en = 1'b1; i_mode = 3'd0;
      end else begin
        i_test_en = 1'b1; i_mode = 3'd1;
      end
      step();
      if (j >= 3) begin
        exp = (j - 2 >= 16) ? chv(7 - ((j - 3) % 8)) : DW'(32'hA000_0000 + j - 2);
        checks++;
        if (o_data_iq !== exp) begin
          errors++; $display("FAIL modesel_data j=%0d got %h exp %h", j, o_data_iq, exp);
        end
      end
    end
    i_frame_hd = 1'b0;
  endtask

  initial begin
    asy_rst = 1'b1; i_frame_hd = 1'b0; i_framn_hd = 1'b0; i_datan_iq = '0;
    i_test_en = 1'b1; i_mode = 3'd0; i_const_iq = '0; i_win_en = 1'b0;
    i_win_start = '0; i_win_end = '0; i_sel_cfg = '0;
    for (int k = 0; k < NCH; k++) i_data_bus[k*DW +: DW] = chv(k);
    set_default_sel();

    test_reset();
    test_pass();
    test_tdm();
    test_tdm_badsel();
    test_window();
    test_ramp();
    test_reset_mid();
    test_mode_sel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
